// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter sequencer sitting between the control decoder
// and the instruction ROM.
//
// It runs an IDLE -> RUN -> DONE handshake. While in RUN the counter can
// increment, take an absolute branch through a writable jump table, take a
// PC-relative branch, or call and return through a small return stack. A
// stall input freezes the counter, the stack and the FSM.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (also clears the jump table)
//   req        start request, level-sampled; it must drop to leave DONE
//   stall      freezes all RUN-state updates for the cycle
//   halt       halt instruction, ends the run
//   br_en      absolute branch to lut[lut_sel] when cond is high
//   rel_en     relative branch by sign-extended rel_off when cond is high
//   cond       branch condition flag
//   lut_sel    jump-table index used by br_en and call_en
//   rel_off    signed relative offset
//   call_en    pushes prog_ctr+1 and jumps to lut[lut_sel]
//   ret_en     pops the return address into prog_ctr
//   lut_we     jump-table write enable (accepted in any state)
//   lut_waddr  jump-table write index
//   lut_wdata  jump-table write data
//   prog_ctr   current instruction address
//   busy       high in RUN
//   done       high in DONE
//   err        sticky stack overflow/underflow flag
//
// Assumes D > OFS_W and STK is a power of 2 no smaller than 2.
module pc_sequencer #(
  parameter int unsigned D       = 12,
  parameter int unsigned LUT_N   = 8,
  parameter int unsigned LW      = 3,
  parameter int unsigned OFS_W   = 8,
  parameter int unsigned STK     = 4,
  parameter int unsigned DONE_PC = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             stall,
  input  logic             halt,
  input  logic             br_en,
  input  logic             rel_en,
  input  logic             cond,
  input  logic [LW-1:0]    lut_sel,
  input  logic [OFS_W-1:0] rel_off,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic             lut_we,
  input  logic [LW-1:0]    lut_waddr,
  input  logic [D-1:0]     lut_wdata,
  output logic [D-1:0]     prog_ctr,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // The stack pointer needs one extra code to represent "full".
  localparam int unsigned SpW   = $clog2(STK + 1);
  localparam int unsigned StkAw = $clog2(STK);
  localparam logic [D-1:0] DonePc = D'(DONE_PC);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic           err_q, err_d;
  logic [SpW-1:0] sp_q, sp_d;
  logic [D-1:0]   stack_q [STK];
  logic [D-1:0]   lut_q [LUT_N];

  logic           push;
  logic [D-1:0]   pc_inc, rel_ext, lut_rd, stk_top;
  logic           stk_empty, stk_full;

  assign pc_inc    = pc_q + D'(1);
  assign rel_ext   = {{(D - OFS_W){rel_off[OFS_W-1]}}, rel_off};
  // Reads see the registered table, so a same-cycle write is not forwarded.
  assign lut_rd    = lut_q[lut_sel];
  assign stk_top   = stack_q[StkAw'(sp_q - SpW'(1))];
  assign stk_empty = (sp_q == '0);
  assign stk_full  = (sp_q == SpW'(STK));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    sp_d    = sp_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        pc_d = '0;
        sp_d = '0;
        if (req) begin
          state_d = StRun;
          err_d   = 1'b0;
        end
      end
      StRun: begin
        if (!stall) begin
          if (halt) begin
            state_d = StDone;
          end else if (ret_en) begin
            if (stk_empty) begin
              err_d   = 1'b1;
              state_d = StDone;
            end else begin
              pc_d = stk_top;
              sp_d = sp_q - SpW'(1);
            end
          end else if (call_en) begin
            if (stk_full) begin
              err_d   = 1'b1;
              state_d = StDone;
            end else begin
              push = 1'b1;
              sp_d = sp_q + SpW'(1);
              pc_d = lut_rd;
            end
          end else if (br_en && cond) begin
            pc_d = lut_rd;
          end else if (rel_en && cond) begin
            pc_d = pc_q + rel_ext;
          end else begin
            pc_d = pc_inc;
          end
          // Landing on the terminal address ends the run whatever got us there.
          if (state_d == StRun && pc_d == DonePc) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (!req) begin
          state_d = StIdle;
          pc_d    = '0;
          sp_d    = '0;
        end
      end
      default: begin
        state_d = StIdle;
        pc_d    = '0;
        sp_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      err_q   <= 1'b0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      sp_q    <= sp_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STK; i++) begin
        stack_q[i] <= '0;
      end
    end else if (push) begin
      stack_q[StkAw'(sp_q)] <= pc_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LUT_N; i++) begin
        lut_q[i] <= '0;
      end
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  assign prog_ctr = pc_q;
  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign err      = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. Expected outputs are queued when the
// stimulus for a cycle is driven and popped/compared one step after the edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, stall, halt, br_en, rel_en, cond, call_en, ret_en, lut_we;
  logic [2:0]  lut_sel, lut_waddr;
  logic [7:0]  rel_off;
  logic [11:0] lut_wdata;
  logic [11:0] prog_ctr;
  logic        busy, done, err;

  typedef struct packed {
    logic [11:0] pc;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  pc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .stall     (stall),
    .halt      (halt),
    .br_en     (br_en),
    .rel_en    (rel_en),
    .cond      (cond),
    .lut_sel   (lut_sel),
    .rel_off   (rel_off),
    .call_en   (call_en),
    .ret_en    (ret_en),
    .lut_we    (lut_we),
    .lut_waddr (lut_waddr),
    .lut_wdata (lut_wdata),
    .prog_ctr  (prog_ctr),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Queue the expectation, clock once, then compare the popped entry.
  task automatic step(input string tag, input logic [11:0] pc, input logic b,
                      input logic d, input logic e);
    exp_t x;
    x = '{pc: pc, busy: b, done: d, err: e};
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check_val({tag, " pc"},   32'(prog_ctr), 32'(x.pc));
    check_val({tag, " busy"}, 32'(busy),     32'(x.busy));
    check_val({tag, " done"}, 32'(done),     32'(x.done));
    check_val({tag, " err"},  32'(err),      32'(x.err));
  endtask

  task automatic call_to(input logic [2:0] sel, input logic [11:0] target);
    call_en = 1'b1;
    lut_sel = sel;
    step("call", target, 1'b1, 1'b0, 1'b0);
    call_en = 1'b0;
  endtask

  task automatic ret_to(input logic [11:0] target);
    ret_en = 1'b1;
    step("ret", target, 1'b1, 1'b0, 1'b0);
    ret_en = 1'b0;
  endtask

  task automatic lut_write(input logic [2:0] a, input logic [11:0] v, input logic e);
    lut_we    = 1'b1;
    lut_waddr = a;
    lut_wdata = v;
    step("lut wr", 12'h000, 1'b0, 1'b0, e);
    lut_we    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    {req, stall, halt, br_en, rel_en, cond, call_en, ret_en, lut_we} = '0;
    lut_sel = '0; lut_waddr = '0; rel_off = '0; lut_wdata = '0;

    #2;
    check_val("reset pc",   32'(prog_ctr), 32'h0);
    check_val("reset busy", 32'(busy),     32'h0);
    check_val("reset done", 32'(done),     32'h0);
    check_val("reset err",  32'(err),      32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Straight-line run to the terminal address.
    req = 1'b1;
    step("start", 12'h000, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 128; i++) step("count", 12'(i), 1'b1, 1'b0, 1'b0);
    step("done pc", 12'd128, 1'b0, 1'b1, 1'b0);
    step("done hold", 12'd128, 1'b0, 1'b1, 1'b0);
    req = 1'b0;
    step("back idle", 12'h000, 1'b0, 1'b0, 1'b0);

    // Absolute and relative branches, including table write-read ordering.
    lut_write(3'd3, 12'h040, 1'b0);
    req = 1'b1;
    step("start2", 12'h000, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) step("count2", 12'(i), 1'b1, 1'b0, 1'b0);
    br_en = 1'b1; cond = 1'b0; lut_sel = 3'd3;
    step("br not taken", 12'h006, 1'b1, 1'b0, 1'b0);
    cond = 1'b1;
    step("br taken", 12'h040, 1'b1, 1'b0, 1'b0);
    br_en = 1'b0; rel_en = 1'b1; rel_off = 8'hFC;
    step("rel back", 12'h03C, 1'b1, 1'b0, 1'b0);
    rel_en = 1'b0; br_en = 1'b1;
    lut_we = 1'b1; lut_waddr = 3'd3; lut_wdata = 12'h002;
    step("br old lut", 12'h040, 1'b1, 1'b0, 1'b0);
    lut_we = 1'b0;
    step("br new lut", 12'h002, 1'b1, 1'b0, 1'b0);
    br_en = 1'b0; rel_en = 1'b1; rel_off = 8'hFC;
    step("rel wrap", 12'hFFE, 1'b1, 1'b0, 1'b0);
    rel_en = 1'b0; cond = 1'b0;
    step("inc", 12'hFFF, 1'b1, 1'b0, 1'b0);
    step("inc wrap", 12'h000, 1'b1, 1'b0, 1'b0);
    halt = 1'b1;
    step("halt", 12'h000, 1'b0, 1'b1, 1'b0);
    halt = 1'b0; req = 1'b0;
    step("idle2", 12'h000, 1'b0, 1'b0, 1'b0);

    // Nested calls, LIFO returns, overflow, then underflow.
    lut_write(3'd0, 12'h100, 1'b0);
    lut_write(3'd1, 12'h200, 1'b0);
    lut_write(3'd2, 12'h300, 1'b0);
    lut_write(3'd4, 12'h400, 1'b0);
    req = 1'b1;
    step("start3", 12'h000, 1'b1, 1'b0, 1'b0);
    call_to(3'd0, 12'h100);
    call_to(3'd1, 12'h200);
    call_to(3'd2, 12'h300);
    call_to(3'd4, 12'h400);
    ret_to(12'h301);
    ret_to(12'h201);
    ret_to(12'h101);
    ret_to(12'h001);
    call_to(3'd0, 12'h100);
    call_to(3'd1, 12'h200);
    call_to(3'd2, 12'h300);
    call_to(3'd4, 12'h400);
    call_en = 1'b1; lut_sel = 3'd0;
    step("overflow", 12'h400, 1'b0, 1'b1, 1'b1);
    call_en = 1'b0; req = 1'b0;
    step("idle err kept", 12'h000, 1'b0, 1'b0, 1'b1);
    req = 1'b1;
    step("start clr err", 12'h000, 1'b1, 1'b0, 1'b0);
    ret_en = 1'b1;
    step("underflow", 12'h000, 1'b0, 1'b1, 1'b1);
    ret_en = 1'b0; req = 1'b0;
    step("idle3", 12'h000, 1'b0, 1'b0, 1'b1);

    // Stall freezes the counter and masks halt.
    req = 1'b1;
    step("start4", 12'h000, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) step("count4", 12'(i), 1'b1, 1'b0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step("stall", 12'd10, 1'b1, 1'b0, 1'b0);
    halt = 1'b1;
    step("stall halt", 12'd10, 1'b1, 1'b0, 1'b0);
    stall = 1'b0;
    step("halt after stall", 12'd10, 1'b0, 1'b1, 1'b0);
    halt = 1'b0; req = 1'b0;
    step("idle4", 12'h000, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-run also clears the jump table.
    req = 1'b1;
    step("start5", 12'h000, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 50; i++) step("count5", 12'(i), 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_val("async rst pc",   32'(prog_ctr), 32'h0);
    check_val("async rst busy", 32'(busy),     32'h0);
    check_val("async rst done", 32'(done),     32'h0);
    #2 reset = 1'b1;
    step("restart", 12'h000, 1'b1, 1'b0, 1'b0);
    br_en = 1'b1; cond = 1'b1; lut_sel = 3'd3;
    step("lut3 cleared", 12'h000, 1'b1, 1'b0, 1'b0);
    br_en = 1'b0;
    step("inc after rst", 12'h001, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the processor's fetch subassembly (program counter plus jump lookup table).
- Adds:
  - a run/done handshake FSM;
  - a writable jump-target table instead of hard-wired data-memory taps;
  - conditional absolute and relative branches;
  - a call/return stack;
  - stall support.
- Sits between the control decoder and the instruction ROM. It drives prog_ctr and done to the top level.

Parameters:
D, 12, program counter width
LUT_N, 8, number of jump-table entries (power of 2)
LW, 3, jump-table index width, log2(LUT_N)
OFS_W, 8, signed relative-branch offset width
STK, 4, return-stack depth
DONE_PC, 128, prog_ctr value that ends the program

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  1  start request, level-sampled
stall  in  1  hold prog_ctr and all state this cycle (RUN only)
halt  in  1  halt instruction decoded
br_en  in  1  absolute branch via jump table
rel_en  in  1  relative branch
cond  in  1  branch condition (ALU zero/parity flag)
lut_sel  in  LW  jump-table index for br_en/call_en
rel_off  in  OFS_W  signed relative offset
call_en  in  1  call through jump table; pushes prog_ctr+1
ret_en  in  1  return; pops the stack
lut_we  in  1  jump-table write enable
lut_waddr  in  LW  jump-table write index
lut_wdata  in  D  jump-table write data
prog_ctr  out  D  current instruction address
busy  out  1  high in RUN
done  out  1  high in DONE
err  out  1  sticky stack overflow/underflow flag

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; prog_ctr=0, busy=0, done=0, err=0.
  - Stack pointer=0 (stack empty); all jump-table entries=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: prog_ctr held at 0. req=1 -> RUN next edge, prog_ctr=0.
  - RUN: busy=1. stall=1 freezes prog_ctr, stack and FSM. Otherwise one update per edge, priority high to low:
    - halt -> DONE, prog_ctr unchanged.
    - ret_en: stack empty -> err=1, go DONE; else prog_ctr=top of stack, pop.
    - call_en: stack full (STK entries) -> err=1, go DONE; else push prog_ctr+1, prog_ctr=lut[lut_sel].
    - br_en & cond -> prog_ctr=lut[lut_sel].
    - rel_en & cond -> prog_ctr = prog_ctr + sign_extend(rel_off), modulo 2^D.
    - otherwise -> prog_ctr+1, modulo 2^D; wraps 2^D-1 -> 0.
  - Transition to DONE when the next prog_ctr equals DONE_PC; prog_ctr is loaded with DONE_PC.
  - br_en or rel_en with cond=0 behaves as increment.
  - DONE: done=1, busy=0, prog_ctr held.
    - req=0 -> IDLE next edge; prog_ctr=0, stack cleared. err is retained.
    - req must drop before a new run can start.
- err is cleared only by reset or by the IDLE -> RUN transition.
- Jump table write:
  - Synchronous; allowed in any state, including during stall.
  - A same-cycle read of the same index returns the old value; the new value is visible next cycle.
- Inputs other than req, lut_* and reset are ignored in IDLE and DONE.
- Latency: all control inputs affect prog_ctr at the next rising edge. Outputs are registered or decoded from registered state only.
- Reset asserted mid-RUN: immediate return to reset values, including the jump table.

Test Plan:
- Reset, req=1, no control inputs -> prog_ctr 0,1,2,...,127 on successive cycles; at 128 done=1, busy=0. Drop req -> IDLE, prog_ctr=0.
- Write lut[3]=0x040; at prog_ctr=5 assert br_en, cond=1, lut_sel=3 -> prog_ctr=0x040. Same with cond=0 -> prog_ctr=6.
- At prog_ctr=0x040, rel_en=1, cond=1, rel_off=-4 (8'hFC) -> prog_ctr=0x03C. At prog_ctr=0x002, rel_off=-4 -> prog_ctr=0xFFE (wrap).
- Perform 4 nested calls, then ret four times -> prog_ctr returns to each caller+1 in LIFO order.
  - A 5th nested call -> err=1, done=1.
  - ret with empty stack after a fresh start -> err=1, done=1.
- stall=1 for 3 cycles at prog_ctr=10 -> prog_ctr stays 10. halt with stall=1 is ignored until stall=0.
- Assert reset=0 mid-RUN at prog_ctr=50 -> prog_ctr=0, busy=0 asynchronously (before the next edge); lut[3] reads 0.
